// File: rtl/sram_bus_arbiter_if.sv
// Bundle of the IF/MEM request ports and the SRAM pin group.
// The arbiter takes the slave view; the pipeline/SRAM side takes the master view.
interface sram_bus_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              stallreq_if;
    logic              stallreq_mem;
    logic              busy;

    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_data_oe;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready,
               stallreq_if, stallreq_mem, busy,
               sram_addr, sram_wdata, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, sram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready,
               stallreq_if, stallreq_mem, busy,
               sram_addr, sram_wdata, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM between instruction fetch and the MEM stage (MEM has priority)
// using an IDLE -> ACCESS -> DONE wait-state sequence.
module sram_bus_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    sram_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       grant_mem;
    logic       grant_we;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.mem_req || bus.if_req) state_nxt = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes, address and data are registered so the SRAM pins never glitch;
    // ready pulses are set on the ACCESS->DONE edge so they land in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt              <= 4'd0;
            grant_mem        <= 1'b0;
            grant_we         <= 1'b0;
            bus.sram_ce_n    <= 1'b1;
            bus.sram_oe_n    <= 1'b1;
            bus.sram_we_n    <= 1'b1;
            bus.sram_data_oe <= 1'b0;
            bus.sram_addr    <= '0;
            bus.sram_wdata   <= '0;
            bus.if_ready     <= 1'b0;
            bus.mem_ready    <= 1'b0;
            bus.if_rdata     <= '0;
            bus.mem_rdata    <= '0;
        end else begin
            bus.if_ready  <= 1'b0;
            bus.mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mem_req) begin
                        grant_mem        <= 1'b1;
                        grant_we         <= bus.mem_we;
                        bus.sram_addr    <= bus.mem_addr;
                        bus.sram_wdata   <= bus.mem_wdata;
                        bus.sram_ce_n    <= 1'b0;
                        bus.sram_oe_n    <= bus.mem_we;
                        bus.sram_we_n    <= ~bus.mem_we;
                        bus.sram_data_oe <= bus.mem_we;
                        cnt              <= WAIT_INIT;
                    end else if (bus.if_req) begin
                        grant_mem        <= 1'b0;
                        grant_we         <= 1'b0;
                        bus.sram_addr    <= bus.if_addr;
                        bus.sram_ce_n    <= 1'b0;
                        bus.sram_oe_n    <= 1'b0;
                        bus.sram_we_n    <= 1'b1;
                        bus.sram_data_oe <= 1'b0;
                        cnt              <= WAIT_INIT;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!grant_we) begin
                            if (grant_mem) bus.mem_rdata <= bus.sram_rdata;
                            else           bus.if_rdata  <= bus.sram_rdata;
                        end
                        bus.sram_ce_n    <= 1'b1;
                        bus.sram_oe_n    <= 1'b1;
                        bus.sram_we_n    <= 1'b1;
                        bus.sram_data_oe <= 1'b0;
                        bus.if_ready     <= ~grant_mem;
                        bus.mem_ready    <= grant_mem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.stallreq_if  = bus.if_req  & ~bus.if_ready;
    assign bus.stallreq_mem = bus.mem_req & ~bus.mem_ready;
endmodule
